// File: rtl/firebird7_in_gate1_tessent_data_mux_pkg.sv
// Shared types and helpers for the firebird7_in gate1 IJTAG override data mux.
package firebird7_in_gate1_tessent_data_mux_pkg;

   typedef enum logic [1:0] {
      FUNC,
      SETTLE_TO_OVR,
      OVR,
      SETTLE_TO_FUNC
   } chan_state_t;

   // Each channel contributes one enable bit plus W override data bits.
   function automatic int tdr_len(input int ch, input int w);
      return ch * (w + 1);
   endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_chan.sv
// One mux channel: break-before-make source FSM with a registered data output.
module firebird7_in_gate1_tessent_data_mux_chan
   import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
   parameter int W = 19,
   parameter int SETTLE = 2,
   parameter logic [W-1:0] SAFE_VALUE = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         upd_en,
   input  logic [W-1:0] upd_data,
   input  logic [W-1:0] func_data,
   output logic [W-1:0] data_out,
   output logic         override_active
);

   localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'((SETTLE > 0) ? SETTLE - 1 : 0);

   chan_state_t   state;
   logic [CW-1:0] cnt;

   // Outputs are registered from the state being entered, so data_out always matches the current state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= FUNC;
         cnt             <= '0;
         data_out        <= '0;
         override_active <= 1'b0;
      end else begin
         case (state)
            FUNC: begin
               if (upd_en && SETTLE == 0) begin
                  state           <= OVR;
                  data_out        <= upd_data;
                  override_active <= 1'b1;
               end else if (upd_en) begin
                  state           <= SETTLE_TO_OVR;
                  cnt             <= CNT_LOAD;
                  data_out        <= SAFE_VALUE;
                  override_active <= 1'b0;
               end else begin
                  data_out        <= func_data;
                  override_active <= 1'b0;
               end
            end
            SETTLE_TO_OVR: begin
               if (cnt == '0) begin
                  state           <= OVR;
                  data_out        <= upd_data;
                  override_active <= 1'b1;
               end else begin
                  cnt             <= cnt - CW'(1);
                  data_out        <= SAFE_VALUE;
                  override_active <= 1'b0;
               end
            end
            OVR: begin
               if (!upd_en && SETTLE == 0) begin
                  state           <= FUNC;
                  data_out        <= func_data;
                  override_active <= 1'b0;
               end else if (!upd_en) begin
                  state           <= SETTLE_TO_FUNC;
                  cnt             <= CNT_LOAD;
                  data_out        <= SAFE_VALUE;
                  override_active <= 1'b0;
               end else begin
                  data_out        <= upd_data;
                  override_active <= 1'b1;
               end
            end
            SETTLE_TO_FUNC: begin
               if (cnt == '0) begin
                  state           <= FUNC;
                  data_out        <= func_data;
                  override_active <= 1'b0;
               end else begin
                  cnt             <= cnt - CW'(1);
                  data_out        <= SAFE_VALUE;
                  override_active <= 1'b0;
               end
            end
            default: begin
               state           <= FUNC;
               cnt             <= '0;
               data_out        <= SAFE_VALUE;
               override_active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_tdr.sv
// Multi-channel IJTAG override mux: embedded TDR (shift/update) driving CH settle-guarded channels.
module firebird7_in_gate1_tessent_data_mux_tdr
   import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
   parameter int CH = 2,
   parameter int W = 19,
   parameter int SETTLE = 2,
   parameter logic [W-1:0] SAFE_VALUE = '0
) (
   input  logic            ijtag_tck,
   input  logic            ijtag_reset,
   input  logic            ijtag_sel,
   input  logic            ijtag_ce,
   input  logic            ijtag_se,
   input  logic            ijtag_ue,
   input  logic            ijtag_si,
   output logic            ijtag_so,
   input  logic [CH*W-1:0] functional_data_in,
   output logic [CH*W-1:0] data_out,
   output logic [CH-1:0]   override_active
);

   localparam int L = tdr_len(CH, W);

   logic [L-1:0] shift_reg;
   logic [L-1:0] upd_reg;
   logic [L-1:0] capture_vec;

   assign ijtag_so = shift_reg[0];

   // Capture has priority over shift, shift over update; deselected TDR holds both registers.
   always_ff @(posedge ijtag_tck) begin
      if (ijtag_reset) begin
         shift_reg <= '0;
         upd_reg   <= '0;
      end else if (ijtag_sel) begin
         if (ijtag_ce) begin
            shift_reg <= capture_vec;
         end else if (ijtag_se) begin
            shift_reg <= {ijtag_si, shift_reg[L-1:1]};
         end else if (ijtag_ue) begin
            upd_reg <= shift_reg;
         end
      end
   end

   for (genvar c = 0; c < CH; c++) begin : g_chan
      assign capture_vec[c*(W+1)]         = override_active[c];
      assign capture_vec[c*(W+1)+1 +: W]  = data_out[c*W +: W];

      firebird7_in_gate1_tessent_data_mux_chan #(
         .W          (W),
         .SETTLE     (SETTLE),
         .SAFE_VALUE (SAFE_VALUE)
      ) u_chan (
         .clk             (ijtag_tck),
         .reset           (ijtag_reset),
         .upd_en          (upd_reg[c*(W+1)]),
         .upd_data        (upd_reg[c*(W+1)+1 +: W]),
         .func_data       (functional_data_in[c*W +: W]),
         .data_out        (data_out[c*W +: W]),
         .override_active (override_active[c])
      );
   end

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_tdr.sv
// Bench for the IJTAG override mux: directed walk-through plus randomized traffic against a behavioural model.
module tb_firebird7_in_gate1_tessent_data_mux_tdr;

   localparam int CH = 2;
   localparam int W  = 4;
   localparam int L  = CH * (W + 1);
   localparam logic [W-1:0] SAFE = '0;

   logic            ijtag_tck = 1'b0;
   logic            ijtag_reset = 1'b1;
   logic            ijtag_sel = 1'b0;
   logic            ijtag_ce = 1'b0;
   logic            ijtag_se = 1'b0;
   logic            ijtag_ue = 1'b0;
   logic            ijtag_si = 1'b0;
   logic [CH*W-1:0] func_in = '0;

   logic            so2, so0;
   logic [CH*W-1:0] dout2, dout0;
   logic [CH-1:0]   ovr2, ovr0;

   int n_compared = 0;
   int n_mismatched = 0;
   bit check_en = 1'b0;

   always #5 ijtag_tck = ~ijtag_tck;

   firebird7_in_gate1_tessent_data_mux_tdr #(
      .CH(CH), .W(W), .SETTLE(2), .SAFE_VALUE(SAFE)
   ) dut2 (
      .ijtag_tck(ijtag_tck), .ijtag_reset(ijtag_reset), .ijtag_sel(ijtag_sel),
      .ijtag_ce(ijtag_ce), .ijtag_se(ijtag_se), .ijtag_ue(ijtag_ue),
      .ijtag_si(ijtag_si), .ijtag_so(so2), .functional_data_in(func_in),
      .data_out(dout2), .override_active(ovr2)
   );

   firebird7_in_gate1_tessent_data_mux_tdr #(
      .CH(CH), .W(W), .SETTLE(0), .SAFE_VALUE(SAFE)
   ) dut0 (
      .ijtag_tck(ijtag_tck), .ijtag_reset(ijtag_reset), .ijtag_sel(ijtag_sel),
      .ijtag_ce(ijtag_ce), .ijtag_se(ijtag_se), .ijtag_ue(ijtag_ue),
      .ijtag_si(ijtag_si), .ijtag_so(so0), .functional_data_in(func_in),
      .data_out(dout0), .override_active(ovr0)
   );

   // Model: index 0 mirrors the SETTLE=2 build, index 1 the SETTLE=0 build.
   int              settle_of[2] = '{2, 0};
   logic [L-1:0]    m_shift[2];
   logic [L-1:0]    m_upd[2];
   logic [CH*W-1:0] exp_data[2];
   logic [CH-1:0]   exp_ovr[2];
   int              busy[2][CH];
   bit              src[2][CH];
   bit              tgt[2][CH];

   always @(posedge ijtag_tck) begin
      for (int i = 0; i < 2; i++) begin
         logic [CH*W-1:0] old_out;
         logic [CH-1:0]   old_ovr;
         logic [L-1:0]    old_upd;
         old_out = exp_data[i];
         old_ovr = exp_ovr[i];
         old_upd = m_upd[i];
         if (ijtag_reset) begin
            m_shift[i]  = '0;
            m_upd[i]    = '0;
            exp_data[i] = '0;
            exp_ovr[i]  = '0;
            for (int c = 0; c < CH; c++) begin
               busy[i][c] = 0;
               src[i][c]  = 1'b0;
               tgt[i][c]  = 1'b0;
            end
         end else begin
            if (ijtag_sel) begin
               if (ijtag_ce) begin
                  for (int c = 0; c < CH; c++) begin
                     m_shift[i][c*(W+1)]        = old_ovr[c];
                     m_shift[i][c*(W+1)+1 +: W] = old_out[c*W +: W];
                  end
               end else if (ijtag_se) begin
                  m_shift[i] = {ijtag_si, m_shift[i][L-1:1]};
               end else if (ijtag_ue) begin
                  m_upd[i] = m_shift[i];
               end
            end
            // A source change costs settle_of[i] safe cycles; requests arriving meanwhile wait for it to finish.
            for (int c = 0; c < CH; c++) begin
               bit desired;
               desired = old_upd[c*(W+1)];
               if (busy[i][c] > 0) begin
                  busy[i][c]--;
                  if (busy[i][c] == 0) src[i][c] = tgt[i][c];
               end else if (desired != src[i][c]) begin
                  if (settle_of[i] == 0) begin
                     src[i][c] = desired;
                  end else begin
                     busy[i][c] = settle_of[i];
                     tgt[i][c]  = desired;
                  end
               end
               if (busy[i][c] > 0)
                  exp_data[i][c*W +: W] = SAFE;
               else if (src[i][c])
                  exp_data[i][c*W +: W] = old_upd[c*(W+1)+1 +: W];
               else
                  exp_data[i][c*W +: W] = func_in[c*W +: W];
               exp_ovr[i][c] = (busy[i][c] == 0) && src[i][c];
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every negedge after reset, both builds are held against the model.
   always @(negedge ijtag_tck) begin
      if (check_en) begin
         checkOutput("s2 data_out", 32'(dout2), 32'(exp_data[0]));
         checkOutput("s2 override_active", 32'(ovr2), 32'(exp_ovr[0]));
         checkOutput("s2 ijtag_so", 32'(so2), 32'(m_shift[0][0]));
         checkOutput("s0 data_out", 32'(dout0), 32'(exp_data[1]));
         checkOutput("s0 override_active", 32'(ovr0), 32'(exp_ovr[1]));
         checkOutput("s0 ijtag_so", 32'(so0), 32'(m_shift[1][0]));
      end
   end

   task automatic applyStimulus(input logic sel, input logic ce, input logic se,
                                input logic ue, input logic si);
      ijtag_sel = sel;
      ijtag_ce  = ce;
      ijtag_se  = se;
      ijtag_ue  = ue;
      ijtag_si  = si;
      @(negedge ijtag_tck);
   endtask

   task automatic shiftWord(input logic [L-1:0] v);
      for (int i = 0; i < L; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, v[i]);
   endtask

   initial begin
      logic [L-1:0] got;
      @(negedge ijtag_tck);
      ijtag_reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0);
      check_en = 1'b1;
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("reset data_out", 32'(dout2), 32'h0);
      checkOutput("reset override_active", 32'(ovr2), 32'h0);
      checkOutput("reset so", 32'(so2), 32'h0);

      ijtag_reset = 1'b0;
      func_in = 8'hA5;
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("func path", 32'(dout2), 32'hA5);
      checkOutput("func ovr", 32'(ovr2), 32'h0);

      // ch0 override 3 through a 2-cycle safe window
      shiftWord(10'b00000_0011_1);
      applyStimulus(1, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("settle1 data", 32'(dout2), 32'hA0);
      checkOutput("settle1 ovr", 32'(ovr2), 32'h0);
      checkOutput("s0 immediate data", 32'(dout0), 32'hA3);
      checkOutput("s0 immediate ovr", 32'(ovr0), 32'h1);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("settle2 data", 32'(dout2), 32'hA0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("ovr data", 32'(dout2), 32'hA3);
      checkOutput("ovr active", 32'(ovr2), 32'h1);

      // data change while in OVR: no safe cycles
      shiftWord(10'b00000_1100_1);
      applyStimulus(1, 0, 0, 1, 0);
      checkOutput("ovr data hold", 32'(dout2), 32'hA3);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("ovr data change", 32'(dout2), 32'hAC);
      checkOutput("ovr data change ovr", 32'(ovr2), 32'h1);

      // capture then scan out LSB first
      applyStimulus(1, 1, 0, 0, 0);
      for (int i = 0; i < L; i++) begin
         got[i] = so2;
         applyStimulus(1, 0, 1, 0, 0);
      end
      checkOutput("capture scan-out", 32'(got), 32'(10'b1010_0_1100_1));

      // back to FUNC
      applyStimulus(1, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
      checkOutput("back to func", 32'(dout2), 32'hA5);

      // enable=1 then enable=0 two cycles later, mid-settle
      shiftWord(10'b00000_0110_1);
      applyStimulus(1, 0, 0, 1, 0);
      applyStimulus(1, 0, 1, 0, 0);
      checkOutput("mid1 data", 32'(dout2), 32'hA0);
      applyStimulus(1, 0, 0, 1, 0);
      checkOutput("mid2 data", 32'(dout2), 32'hA0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("mid window done data", 32'(dout2), 32'hA3);
      checkOutput("mid window done ovr", 32'(ovr2), 32'h1);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("second window 1", 32'(dout2), 32'hA0);
      checkOutput("second window ovr", 32'(ovr2), 32'h0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("second window 2", 32'(dout2), 32'hA0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("func after second window", 32'(dout2), 32'hA5);

      // ce+se+ue together: capture only
      checkOutput("pre-shift so", 32'(so2), 32'h0);
      applyStimulus(1, 0, 1, 0, 0);
      checkOutput("shifted so", 32'(so2), 32'h1);
      applyStimulus(1, 1, 1, 1, 0);
      checkOutput("capture priority so", 32'(so2), 32'h0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
      checkOutput("no update with capture", 32'(dout2), 32'hA5);

      // reset during SETTLE_TO_OVR and mid-shift
      shiftWord(10'b00000_0011_1);
      applyStimulus(1, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0);
      ijtag_reset = 1'b1;
      applyStimulus(1, 0, 1, 0, 1);
      checkOutput("reset mid data", 32'(dout2), 32'h0);
      checkOutput("reset mid ovr", 32'(ovr2), 32'h0);
      checkOutput("reset mid so", 32'(so2), 32'h0);
      checkOutput("reset s0 data", 32'(dout0), 32'h0);
      ijtag_reset = 1'b0;
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("post reset func", 32'(dout2), 32'hA5);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
      checkOutput("post reset stays func", 32'(ovr2), 32'h0);

      // sel=0 blocks ue (SETTLE=0 build)
      shiftWord(10'b00000_0011_1);
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("sel0 blocks ue", 32'(ovr0), 32'h0);
      applyStimulus(1, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("s0 switch ovr", 32'(ovr0), 32'h1);
      checkOutput("s0 switch data", 32'(dout0), 32'hA3);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         ijtag_reset = ($urandom_range(0, 199) == 0);
         func_in     = CH*W'($urandom);
         applyStimulus(($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0),
                       1'($urandom), ($urandom_range(0, 5) == 0), 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
